// File: rtl/input_mapper.sv
// Player-input front end: PS/2 keymap decode, joystick merge, SOCD cleaning,
// autofire gating and coin pulse stretching, one registered vector per player.
module input_mapper #(
  parameter int unsigned PLAYERS      = 2,
  parameter int unsigned FUNCS        = 11,
  parameter int unsigned COIN_FUNC    = 8,
  parameter logic [15:0] COIN_CYCLES  = 16'd4800,
  parameter logic [19:0] AUTOFIRE_DIV = 20'd800000
) (
  input  logic                                clk_sys,
  input  logic                                reset_n,
  input  logic [10:0]                         ps2_key,
  input  logic                                map_wr,
  input  logic [$clog2(PLAYERS*FUNCS)-1:0]    map_addr,
  input  logic [8:0]                          map_code,
  input  logic [PLAYERS*FUNCS-1:0]            joystick,
  input  logic [PLAYERS*FUNCS-1:0]            autofire_en,
  input  logic [1:0]                          socd_mode,
  output logic [PLAYERS*FUNCS-1:0]            player_out
);

  localparam int unsigned SLOTS = PLAYERS * FUNCS;
  localparam int unsigned AW    = $clog2(SLOTS);

  logic [10:0]      key_q;
  logic             tog_q;
  logic             key_evt;
  logic [SLOTS-1:0] key_state;
  logic [SLOTS-1:0] raw;
  logic [SLOTS-1:0] raw_q;
  logic [SLOTS-1:0] cleaned;
  logic [SLOTS-1:0] next_out;
  logic [19:0]      af_cnt;
  logic             af_phase;

  // Returns {last, out_b, out_a}; last=1 means the b side rose most recently.
  function automatic logic [2:0] socd_pair(input logic [1:0] mode,
                                           input logic a, input logic b,
                                           input logic a_q, input logic b_q,
                                           input logic last);
    logic l;
    logic oa;
    logic ob;
    l  = last;
    if (a && !a_q)      l = 1'b0;
    else if (b && !b_q) l = 1'b1;
    oa = a;
    ob = b;
    if (a && b) begin
      if (mode == 2'd1) begin
        oa = 1'b0;
        ob = 1'b0;
      end else if (mode == 2'd2) begin
        oa = ~l;
        ob = l;
      end
    end
    return {l, ob, oa};
  endfunction

  assign key_evt = key_q[10] ^ tog_q;
  assign raw     = key_state | joystick;

  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    logic [8:0] code;
    logic       held;

    // A host write clears the slot and takes priority over a same-cycle key event.
    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        code <= '0;
        held <= 1'b0;
      end else if (map_wr && map_addr == AW'(i)) begin
        code <= map_code;
        held <= 1'b0;
      end else if (key_evt && code != '0 && code == key_q[8:0]) begin
        held <= key_q[9];
      end
    end

    assign key_state[i] = held;
  end

  for (genvar p = 0; p < PLAYERS; p++) begin : g_player
    localparam int unsigned B = p * FUNCS;
    localparam int unsigned C = B + COIN_FUNC;

    logic [2:0]       ud;
    logic [2:0]       lr;
    logic [1:0]       last_q;
    logic [15:0]      coin_cnt;
    logic [FUNCS-1:0] pc;

    assign ud = socd_pair(socd_mode, raw[B],   raw[B+1], raw_q[B],   raw_q[B+1], last_q[0]);
    assign lr = socd_pair(socd_mode, raw[B+2], raw[B+3], raw_q[B+2], raw_q[B+3], last_q[1]);

    always_comb begin
      pc            = raw[B +: FUNCS];
      pc[1:0]       = ud[1:0];
      pc[3:2]       = lr[1:0];
      pc[COIN_FUNC] = raw[C] | (coin_cnt != '0);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        last_q   <= '0;
        coin_cnt <= '0;
      end else begin
        last_q <= {lr[2], ud[2]};
        if (raw[C] && !raw_q[C])
          coin_cnt <= COIN_CYCLES - 16'd1;
        else if (coin_cnt != '0)
          coin_cnt <= coin_cnt - 16'd1;
      end
    end

    assign cleaned[B +: FUNCS] = pc;
  end

  assign next_out = cleaned & ~(autofire_en & {SLOTS{~af_phase}});

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      key_q      <= '0;
      tog_q      <= 1'b0;
      raw_q      <= '0;
      af_cnt     <= '0;
      af_phase   <= 1'b0;
      player_out <= '0;
    end else begin
      key_q <= ps2_key;
      tog_q <= key_q[10];
      raw_q <= raw;
      if (af_cnt == AUTOFIRE_DIV - 20'd1) begin
        af_cnt   <= '0;
        af_phase <= ~af_phase;
      end else begin
        af_cnt <= af_cnt + 20'd1;
      end
      player_out <= next_out;
    end
  end

endmodule

// File: tb/tb_input_mapper.sv
// Directed bench for input_mapper: per-cycle comparison against a timestamp
// based behavioural model plus hand-computed spot checks.
module tb_input_mapper;

  localparam int unsigned SLOTS   = 22;
  localparam int          COIN_N  = 4;
  localparam int          AF_DIV  = 3;

  logic             clk_sys = 1'b0;
  logic             reset_n = 1'b0;
  logic [10:0]      ps2_key = '0;
  logic             map_wr = 1'b0;
  logic [4:0]       map_addr = '0;
  logic [8:0]       map_code = '0;
  logic [21:0]      joystick = '0;
  logic [21:0]      autofire_en = '0;
  logic [1:0]       socd_mode = '0;
  logic [21:0]      player_out;

  int passed = 0;
  int total  = 0;
  logic tgl = 1'b0;
  logic s [12];

  input_mapper #(
    .PLAYERS(2),
    .FUNCS(11),
    .COIN_FUNC(8),
    .COIN_CYCLES(16'd4),
    .AUTOFIRE_DIV(20'd3)
  ) dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .ps2_key(ps2_key),
    .map_wr(map_wr),
    .map_addr(map_addr),
    .map_code(map_code),
    .joystick(joystick),
    .autofire_en(autofire_en),
    .socd_mode(socd_mode),
    .player_out(player_out)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    else passed++;
  endtask

  // Behavioural model: keys tracked per slot, edges by timestamp, autofire
  // phase from the cycle number, coin stretch from time since last rise.
  int          n = 0;
  logic [21:0] ks = '0;
  logic [21:0] raw_prev = '0;
  logic [21:0] exp_out = '0;
  logic [21:0] raw_m;
  logic [21:0] clean;
  logic [10:0] p1 = '0;
  logic [10:0] p2 = '0;
  logic [8:0]  mmap [SLOTS];
  int          rise_t [SLOTS];

  initial begin
    for (int i = 0; i < SLOTS; i++) begin
      mmap[i]   = '0;
      rise_t[i] = 0;
    end
    forever begin
      @(posedge clk_sys or negedge reset_n);
      if (!reset_n) begin
        n = 0; ks = '0; raw_prev = '0; exp_out = '0; p1 = '0; p2 = '0;
        for (int i = 0; i < SLOTS; i++) begin
          mmap[i]   = '0;
          rise_t[i] = 0;
        end
      end else begin
        n++;
        raw_m = ks | joystick;
        for (int i = 0; i < SLOTS; i++)
          if (raw_m[i] && !raw_prev[i]) rise_t[i] = n;
        clean = raw_m;
        for (int p = 0; p < 2; p++) begin
          for (int k = 0; k < 2; k++) begin
            int a;
            a = p * 11 + 2 * k;
            if (raw_m[a] && raw_m[a+1]) begin
              if (socd_mode == 2'd1) begin
                clean[a] = 1'b0; clean[a+1] = 1'b0;
              end else if (socd_mode == 2'd2) begin
                if (rise_t[a+1] > rise_t[a]) clean[a] = 1'b0;
                else clean[a+1] = 1'b0;
              end
            end
          end
          if (rise_t[p*11+8] != 0 && n - rise_t[p*11+8] < COIN_N) clean[p*11+8] = 1'b1;
        end
        if (((n - 1) / AF_DIV) % 2 == 0) clean = clean & ~autofire_en;
        exp_out = clean;
        if (p1[10] != p2[10])
          for (int i = 0; i < SLOTS; i++)
            if (mmap[i] != 9'h000 && mmap[i] == p1[8:0]) ks[i] = p1[9];
        if (map_wr && int'(map_addr) < SLOTS) begin
          mmap[map_addr] = map_code;
          ks[map_addr]   = 1'b0;
        end
        raw_prev = raw_m;
        p2 = p1;
        p1 = ps2_key;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk_sys);
      if (reset_n) check("model", 32'(player_out), 32'(exp_out));
    end
  end

  task automatic tick(input int k);
    repeat (k) @(negedge clk_sys);
  endtask

  task automatic key_event(input logic pressed, input logic [8:0] code);
    tgl     = ~tgl;
    ps2_key = {tgl, pressed, code};
  endtask

  task automatic map_write(input logic [4:0] addr, input logic [8:0] code);
    map_wr = 1'b1; map_addr = addr; map_code = code;
    tick(1);
    map_wr = 1'b0;
  endtask

  initial begin
    tick(2);
    check("reset_out", 32'(player_out), 0);
    reset_n = 1'b1;
    tick(2);

    // keymap decode and latency
    map_write(5'd0, 9'h175);
    key_event(1'b1, 9'h175);
    tick(2); check("ps2_lat2", 32'(player_out[0]), 0);
    tick(1); check("ps2_lat3", 32'(player_out[0]), 1);
    key_event(1'b0, 9'h175); tick(3); check("ps2_release", 32'(player_out[0]), 0);
    key_event(1'b1, 9'h075); tick(3); check("ps2_noext", 32'(player_out[0]), 0);
    key_event(1'b0, 9'h075); tick(1);
    map_write(5'd11, 9'h175);
    key_event(1'b1, 9'h175); tick(3); check("dup_code", 32'(player_out), 32'h000801);
    key_event(1'b0, 9'h175); tick(3); check("dup_release", 32'(player_out), 0);
    map_write(5'd31, 9'h029);
    key_event(1'b1, 9'h029); tick(3); check("addr_oob", 32'(player_out), 0);
    key_event(1'b0, 9'h029); tick(1);

    // joystick latency and asynchronous reset
    joystick[13] = 1'b1;
    tick(1); check("joy_lat1", 32'(player_out[13]), 1);
    #2 reset_n = 1'b0;
    #1 check("async_reset", 32'(player_out), 0);
    tick(1);
    joystick = '0;
    reset_n  = 1'b1;
    tick(1);
    key_event(1'b1, 9'h175); tick(3); check("map_cleared", 32'(player_out[0]), 0);
    key_event(1'b0, 9'h175); tick(1);

    // SOCD
    socd_mode = 2'd1; joystick[3:2] = 2'b11;
    tick(1); check("socd_neutral", 32'(player_out[3:2]), 0);
    joystick[12:11] = 2'b11;
    tick(1); check("socd_neutral_p2", 32'(player_out[12:11]), 0);
    joystick = '0; socd_mode = 2'd2; tick(1);
    joystick[2] = 1'b1; tick(2);
    joystick[3] = 1'b1; tick(1); check("socd_last_right", 32'(player_out[3:2]), 32'b10);
    joystick[3] = 1'b0; tick(1); check("socd_back_left", 32'(player_out[3:2]), 32'b01);
    joystick = '0; tick(1);
    joystick[3:2] = 2'b11; tick(1); check("socd_tie", 32'(player_out[3:2]), 32'b01);
    socd_mode = 2'd0; tick(1); check("socd_off", 32'(player_out[3:2]), 32'b11);
    socd_mode = 2'd3; tick(1); check("socd_mode3", 32'(player_out[3:2]), 32'b11);
    joystick = '0; socd_mode = 2'd0; tick(1);

    // coin stretch and retrigger
    for (int k = 1; k <= 6; k++) begin
      joystick[8] = (k == 1);
      tick(1); check("coin_single", 32'(player_out[8]), 32'(k <= 4));
    end
    joystick[8] = 1'b0; tick(2);
    for (int k = 1; k <= 8; k++) begin
      joystick[8] = (k == 1 || k == 3);
      tick(1); check("coin_retrigger", 32'(player_out[8]), 32'(k <= 6));
    end
    joystick = '0; tick(1);

    // autofire
    autofire_en[4] = 1'b1; joystick[4] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      s[k] = player_out[4];
    end
    for (int k = 0; k < 9; k++) check("af_period", 32'(s[k+3] ^ s[k]), 1);
    autofire_en = '0;
    for (int k = 0; k < 4; k++) begin
      tick(1); check("af_off", 32'(player_out[4]), 1);
    end
    joystick = '0; tick(1);

    // keymap rewrite while held
    map_write(5'd5, 9'h01C);
    key_event(1'b1, 9'h01C); tick(3); check("slot5_press", 32'(player_out[5]), 1);
    map_write(5'd5, 9'h01B);
    tick(1); check("remap_clear", 32'(player_out[5]), 0);
    key_event(1'b0, 9'h01C); tick(3);
    key_event(1'b1, 9'h01C); tick(3); check("old_code_dead", 32'(player_out[5]), 0);
    key_event(1'b1, 9'h01B); tick(3); check("new_code", 32'(player_out[5]), 1);
    key_event(1'b0, 9'h01B); tick(3); check("new_release", 32'(player_out[5]), 0);
    key_event(1'b1, 9'h01B); tick(1);
    map_write(5'd5, 9'h01C);
    tick(3); check("same_cycle_clear", 32'(player_out[5]), 0);
    key_event(1'b0, 9'h01B); tick(4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
